// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock controller.
//   MODE_*  : encodings of the 2-bit mode input.
//   state_t : controller FSM states. IDLE holds clk_out low; the other
//             three states toggle clk_out from the half-period counter.
package cpu_clk_pkg;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_HALT  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_ACT  = 2'd2,
    ST_BURST_ACT = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce, press pulse.
//   clk   in  board clock
//   rst   in  asynchronous active-low reset
//   btn   in  raw asynchronous button level
//   press out one-cycle pulse when an accepted 0->1 transition occurs
// A new level is accepted once DEB_CYCLES consecutive synchronised
// samples agree. DEB_W must be able to hold DEB_CYCLES-1.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             level;
  logic [DEB_W-1:0] cnt;

  // cnt is the number of consecutive matching sample pairs ending at prev,
  // so prev has been seen cnt+1 times in a row. Acceptance is judged on
  // the registered pair (prev, cnt) to keep both views consistent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      press <= 1'b0;
      if (sync2 != prev) begin
        cnt <= '0;
      end else if (cnt != DEB_MAX) begin
        cnt <= cnt + DEB_W'(1);
      end
      if ((cnt == DEB_MAX) && (prev != level)) begin
        level <= prev;
        press <= prev;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: divides the board clock into the CPU clock with
// run / halt / single-step / N-cycle burst modes and a loadable divisor.
//   clk        in  board clock
//   rst        in  asynchronous active-low reset
//   mode       in  00 run, 01 halt, 10 step, 11 burst
//   div_val    in  new half-period in clk cycles (0 is treated as 1)
//   div_load   in  one-cycle strobe capturing div_val
//   step_btn   in  raw push-button for single-step
//   burst_len  in  CPU cycles per burst
//   burst_go   in  one-cycle strobe starting a burst (mode 11 only)
//   clk_out    out divided CPU clock
//   tick       out one-clk pulse with each 0->1 of clk_out
//   running    out high in RUN, STEP_ACT and BURST_ACT
//   cyc_count  out clk_out rising edges since reset (wraps)
//   fsm_state  out current controller state (debug)
// div_load and burst_go are single-cycle strobes with no back-pressure:
// they are sampled on the clk edge where they are high and never held.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = 25000000,
  parameter int DEB_CYCLES   = 1000000,
  parameter int DEB_W        = 20,
  parameter int BURST_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   div_val,
  input  logic               div_load,
  input  logic               step_btn,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               burst_go,
  output logic               clk_out,
  output logic               tick,
  output logic               running,
  output logic [31:0]        cyc_count,
  output logic [1:0]         fsm_state
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t               state;
  logic [CNT_W-1:0]     half;
  logic [CNT_W-1:0]     pending;
  logic                 pend_valid;
  logic [CNT_W-1:0]     hcnt;
  logic [BURST_W-1:0]   remaining;
  logic                 press;
  logic                 toggling;
  logic                 wrap;
  logic                 take_pending;
  logic [CNT_W-1:0]     div_fixed;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (step_btn),
    .press (press)
  );

  assign div_fixed    = (div_val == '0) ? ONE : div_val;
  assign toggling     = (state != ST_IDLE);
  assign wrap         = toggling && (hcnt == half - ONE);
  // A new half only lands on a phase boundary (or while stopped), so no
  // phase is ever cut short or stretched mid-way.
  assign take_pending = pend_valid && (wrap || !toggling);
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      running    <= 1'b0;
      cyc_count  <= '0;
      half       <= HALF_RST;
      pending    <= HALF_RST;
      pend_valid <= 1'b0;
      hcnt       <= '0;
      remaining  <= '0;
    end else begin
      tick <= 1'b0;

      if (div_load) begin
        pending    <= div_fixed;
        pend_valid <= 1'b1;
      end else if (take_pending) begin
        pend_valid <= 1'b0;
      end
      if (take_pending) begin
        half <= pending;
      end

      case (state)
        ST_IDLE: begin
          clk_out <= 1'b0;
          hcnt    <= '0;
          if (mode == MODE_RUN) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if ((mode == MODE_STEP) && press) begin
            state   <= ST_STEP_ACT;
            running <= 1'b1;
          end else if ((mode == MODE_BURST) && burst_go && (burst_len != '0)) begin
            state     <= ST_BURST_ACT;
            running   <= 1'b1;
            remaining <= burst_len;
          end
        end
        default: begin
          if (!wrap) begin
            hcnt <= hcnt + ONE;
          end else begin
            hcnt    <= '0;
            clk_out <= ~clk_out;
            if (!clk_out) begin
              // Rising edge of the CPU clock.
              tick      <= 1'b1;
              cyc_count <= cyc_count + 32'd1;
              if (state == ST_BURST_ACT) begin
                remaining <= remaining - BURST_W'(1);
              end
            end else begin
              // Falling edge: the only point where a toggling state may
              // stop, so the CPU clock always parks low after a full high.
              if (((state == ST_RUN) && (mode != MODE_RUN)) ||
                  (state == ST_STEP_ACT) ||
                  ((state == ST_BURST_ACT) && (remaining == '0))) begin
                state   <= ST_IDLE;
                running <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with DEFAULT_HALF=4, DEB_CYCLES=8.
// Expected waveforms come from phase arithmetic on the CPU-clock timeline
// (toggle times from half-period lengths), not from the controller logic.
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  localparam int CNT_W   = 26;
  localparam int HALF0   = 4;
  localparam int DEB     = 8;
  localparam int DEB_W   = 4;
  localparam int BURST_W = 16;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   div_val;
  logic               div_load;
  logic               step_btn;
  logic [BURST_W-1:0] burst_len;
  logic               burst_go;
  logic               clk_out;
  logic               tick;
  logic               running;
  logic [31:0]        cyc_count;
  logic [1:0]         fsm_state;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (HALF0),
    .DEB_CYCLES   (DEB),
    .DEB_W        (DEB_W),
    .BURST_W      (BURST_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .div_val   (div_val),
    .div_load  (div_load),
    .step_btn  (step_btn),
    .burst_len (burst_len),
    .burst_go  (burst_go),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cyc_count (cyc_count),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  exp_q[$];      // {clk_out, tick, running} per clk cycle
  logic [31:0] model_cyc;     // expected cyc_count

  task automatic nxt();
    @(negedge clk);
  endtask

  // Level of clk_out j cycles after a rising edge: phases of length ch
  // until offset w, phases of length nh afterwards.
  function automatic int div_lvl(int j, int ch, int w, int nh);
    int t;
    if (j < w) t = j / ch;
    else       t = w / ch + (j - w) / nh;
    return (t % 2 == 0) ? 1 : 0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [2:0] o;
    rst = 1'b0; mode = MODE_HALT; div_val = '0; div_load = 1'b0;
    step_btn = 1'b0; burst_len = '0; burst_go = 1'b0;
    nxt(); nxt();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (cyc_count !== 32'd0) begin errors++; $display("FAIL reset_cyc_count: got %0d expected 0", cyc_count); end
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      nxt();
      o = {clk_out, tick, running};
      checks++; if (o !== 3'b000) begin errors++; $display("FAIL halt_idle c=%0d: got %b expected 000", c, o); end
    end
    model_cyc = '0;
  endtask

  task automatic test_run();
    logic [2:0] e, o;
    int lv, tk;
    exp_q.delete();
    for (int j = 0; j <= 100; j++) begin
      lv = (j / HALF0) % 2;
      tk = (j >= HALF0 && j % (2 * HALF0) == HALF0) ? 1 : 0;
      exp_q.push_back({lv[0], tk[0], 1'b1});
      model_cyc += 32'(tk);
    end
    mode = MODE_RUN;
    for (int j = 0; j <= 100; j++) begin
      nxt();
      e = exp_q.pop_front();
      o = {clk_out, tick, running};
      checks++; if (o !== e) begin errors++; $display("FAIL run_wave j=%0d: got %b expected %b", j, o, e); end
    end
    checks++; if (cyc_count !== model_cyc) begin errors++; $display("FAIL run_cyc_count: got %0d expected %0d", cyc_count, model_cyc); end
  endtask

  task automatic test_div();
    int vals[5];
    int ch, nh, r, w, jend, lv, pl, tk;
    logic [2:0] e, o;
    vals[0] = 1;
    vals[1] = 0;
    vals[2] = int'($urandom_range(2, 5));
    vals[3] = int'($urandom_range(0, 5));
    vals[4] = HALF0;
    ch = HALF0;
    for (int i = 0; i < 5; i++) begin
      nh = (vals[i] == 0) ? 1 : vals[i];
      r  = int'($urandom_range(0, ch - 1));
      // Load captured at offset r+1; it lands on the first boundary after that.
      w  = ((r + 2 + ch - 1) / ch) * ch;
      exp_q.delete();
      jend = 0;
      for (int j = 1; jend == 0; j++) begin
        lv = div_lvl(j, ch, w, nh);
        pl = div_lvl(j - 1, ch, w, nh);
        tk = (lv == 1 && pl == 0) ? 1 : 0;
        exp_q.push_back({lv[0], tk[0], 1'b1});
        model_cyc += 32'(tk);
        if (tk == 1 && j > w + 2 * nh) jend = j;
      end
      for (int j = 1; j <= jend; j++) begin
        div_val  = CNT_W'(vals[i]);
        div_load = (j - 1 == r);
        nxt();
        e = exp_q.pop_front();
        o = {clk_out, tick, running};
        checks++; if (o !== e) begin errors++; $display("FAIL div_wave v=%0d j=%0d: got %b expected %b", vals[i], j, o, e); end
      end
      div_load = 1'b0;
      checks++; if (cyc_count !== model_cyc) begin errors++; $display("FAIL div_cyc_count v=%0d: got %0d expected %0d", vals[i], cyc_count, model_cyc); end
      ch = nh;
    end
  endtask

  task automatic test_halt();
    logic [2:0] e, o;
    // Entered right after a rising edge with half = HALF0.
    mode = MODE_HALT;
    for (int j = 1; j <= 20; j++) begin
      nxt();
      e = (j < HALF0) ? 3'b101 : 3'b000;
      o = {clk_out, tick, running};
      checks++; if (o !== e) begin errors++; $display("FAIL halt_wave j=%0d: got %b expected %b", j, o, e); end
    end
    checks++; if (cyc_count !== model_cyc) begin errors++; $display("FAIL halt_cyc_frozen: got %0d expected %0d", cyc_count, model_cyc); end
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL halt_state: got %0d expected %0d", fsm_state, ST_IDLE); end
  endtask

  task automatic test_step();
    int rises, first_rise, high_n, run_n, tk_n, len;
    logic prev;
    logic [7:0] pat;
    // Bounce for 5 cycles, hold 1 for 20, release for 25.
    mode = MODE_STEP;
    rises = 0; first_rise = -1; high_n = 0; run_n = 0; tk_n = 0; prev = 1'b0;
    pat = 8'($urandom);
    for (int c = 0; c < 50; c++) begin
      if (c < 5)       step_btn = (c == 4) ? 1'b0 : pat[c];
      else if (c < 25) step_btn = 1'b1;
      else             step_btn = 1'b0;
      nxt();
      if (clk_out && !prev) begin rises++; if (first_rise < 0) first_rise = c; end
      prev = clk_out;
      if (clk_out) high_n++;
      if (running) run_n++;
      if (tick) tk_n++;
    end
    model_cyc += 32'd1;
    checks++; if (rises !== 1) begin errors++; $display("FAIL step_rises: got %0d expected 1", rises); end
    checks++; if (first_rise < 5 + DEB + 2 || first_rise > 5 + DEB + HALF0 + 8) begin
      errors++; $display("FAIL step_rise_time: got %0d expected %0d..%0d", first_rise, 5 + DEB + 2, 5 + DEB + HALF0 + 8); end
    checks++; if (high_n !== HALF0) begin errors++; $display("FAIL step_high_len: got %0d expected %0d", high_n, HALF0); end
    checks++; if (run_n !== 2 * HALF0) begin errors++; $display("FAIL step_running_len: got %0d expected %0d", run_n, 2 * HALF0); end
    checks++; if (tk_n !== 1) begin errors++; $display("FAIL step_ticks: got %0d expected 1", tk_n); end
    checks++; if (cyc_count !== model_cyc) begin errors++; $display("FAIL step_cyc_count: got %0d expected %0d", cyc_count, model_cyc); end
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL step_state: got %0d expected %0d", fsm_state, ST_IDLE); end

    // Short bounce: never DEB stable highs, so no press.
    len = int'($urandom_range(2, DEB - 1));
    pat = 8'($urandom) | 8'd1;
    rises = 0; run_n = 0;
    for (int c = 0; c < 40; c++) begin
      step_btn = (c < len) ? pat[c] : 1'b0;
      nxt();
      if (clk_out) rises++;
      if (running) run_n++;
    end
    checks++; if (rises !== 0 || run_n !== 0) begin errors++; $display("FAIL step_short_bounce: got high=%0d running=%0d expected 0 0", rises, run_n); end

    // Press while halted is dropped, not replayed on entering step mode.
    mode = MODE_HALT;
    rises = 0;
    for (int c = 0; c < 60; c++) begin
      step_btn = (c < 20) ? 1'b1 : 1'b0;
      if (c == 40) mode = MODE_STEP;
      nxt();
      if (clk_out || running) rises++;
    end
    checks++; if (rises !== 0) begin errors++; $display("FAIL step_discard: got %0d active cycles expected 0", rises); end
    checks++; if (cyc_count !== model_cyc) begin errors++; $display("FAIL step_discard_cyc: got %0d expected %0d", cyc_count, model_cyc); end
  endtask

  task automatic test_burst();
    int lens[3];
    int span, jm, lv, tk, rn;
    logic [2:0] e, o;
    lens[0] = 5;
    lens[1] = int'($urandom_range(1, 6));
    lens[2] = int'($urandom_range(1, 6));
    mode = MODE_BURST;
    for (int i = 0; i < 3; i++) begin
      span = 2 * HALF0 * lens[i];
      jm = (i > 0) ? int'($urandom_range(1, span - 1)) : -1;
      exp_q.delete();
      for (int j = 0; j <= span + 5; j++) begin
        lv = (j < span) ? (j / HALF0) % 2 : 0;
        tk = (j < span && j % (2 * HALF0) == HALF0) ? 1 : 0;
        rn = (j < span) ? 1 : 0;
        exp_q.push_back({lv[0], tk[0], rn[0]});
        model_cyc += 32'(tk);
      end
      burst_len = BURST_W'(lens[i]);
      burst_go  = 1'b1;
      for (int j = 0; j <= span + 5; j++) begin
        nxt();
        burst_go = 1'b0;
        if (j == jm) mode = MODE_HALT;   // must not cut the burst short
        e = exp_q.pop_front();
        o = {clk_out, tick, running};
        checks++; if (o !== e) begin errors++; $display("FAIL burst_wave len=%0d j=%0d: got %b expected %b", lens[i], j, o, e); end
      end
      checks++; if (cyc_count !== model_cyc) begin errors++; $display("FAIL burst_cyc_count len=%0d: got %0d expected %0d", lens[i], cyc_count, model_cyc); end
      checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL burst_end_state len=%0d: got %0d expected %0d", lens[i], fsm_state, ST_IDLE); end
      mode = MODE_BURST;
    end
    // Zero length burst is ignored.
    burst_len = '0;
    burst_go  = 1'b1;
    for (int j = 0; j < 20; j++) begin
      nxt();
      burst_go = 1'b0;
      o = {clk_out, tick, running};
      checks++; if (o !== 3'b000) begin errors++; $display("FAIL burst_zero j=%0d: got %b expected 000", j, o); end
    end
    checks++; if (cyc_count !== model_cyc) begin errors++; $display("FAIL burst_zero_cyc: got %0d expected %0d", cyc_count, model_cyc); end
  endtask

  task automatic test_async_reset();
    int lv, tk;
    logic [2:0] e, o;
    mode      = MODE_BURST;
    burst_len = BURST_W'(5);
    burst_go  = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      nxt();
      burst_go = 1'b0;
      lv = (j / HALF0) % 2;
      tk = (j % (2 * HALF0) == HALF0) ? 1 : 0;
      e  = {lv[0], tk[0], 1'b1};
      o  = {clk_out, tick, running};
      checks++; if (o !== e) begin errors++; $display("FAIL areset_pre j=%0d: got %b expected %b", j, o, e); end
    end
    // Mid high phase; assert reset between clock edges.
    #2 rst = 1'b0;
    #1;
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL areset_clk_out: got %b expected 0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL areset_tick: got %b expected 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL areset_running: got %b expected 0", running); end
    checks++; if (cyc_count !== 32'd0) begin errors++; $display("FAIL areset_cyc_count: got %0d expected 0", cyc_count); end
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL areset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
    model_cyc = '0;
    nxt();
    mode = MODE_RUN;
    nxt();
    rst = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      nxt();
      lv = (j / HALF0) % 2;
      tk = (j >= HALF0 && j % (2 * HALF0) == HALF0) ? 1 : 0;
      model_cyc += 32'(tk);
      e = {lv[0], tk[0], 1'b1};
      o = {clk_out, tick, running};
      checks++; if (o !== e) begin errors++; $display("FAIL areset_resume j=%0d: got %b expected %b", j, o, e); end
    end
    checks++; if (cyc_count !== model_cyc) begin errors++; $display("FAIL areset_resume_cyc: got %0d expected %0d", cyc_count, model_cyc); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_run();
    test_div();
    test_halt();
    test_step();
    test_burst();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
